// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the alignment rule. Sub-word support is gated by LSU_SUBWORD_EN.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
`ifdef LSU_SUBWORD_EN
        ,
        WRITE  = 2'd3
`endif
    } lsu_state_t;

    // True when the request must be rejected without touching memory.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        case (size)
            SZ_WORD: bad = (addrLo != 2'b00);
`ifdef LSU_SUBWORD_EN
            SZ_HALF: bad = addrLo[0];
            SZ_BYTE: bad = 1'b0;
`endif
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data, and merges
// store data into the current memory word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        isSigned,
    input  logic [31:0] readData,
    input  logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic [31:0] storeMerged
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Select the addressed lane(s), extend for loads, splice for stores.
    always_comb begin
        byteSel     = readData[{addrLo, 3'b000} +: 8];
        halfSel     = addrLo[1] ? readData[31:16] : readData[15:0];
        loadData    = readData;
        storeMerged = readData;
        case (size)
            SZ_BYTE: begin
                loadData = {{24{isSigned & byteSel[7]}}, byteSel};
                storeMerged[{addrLo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                loadData = {{16{isSigned & halfSel[15]}}, halfSel};
                if (addrLo[1]) begin
                    storeMerged[31:16] = wdata[15:0];
                end else begin
                    storeMerged[15:0] = wdata[15:0];
                end
            end
            default: begin
                storeMerged = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one pipeline access at a time, performs it
// against a combinational-read data memory and returns a one-cycle response.
// Define LSU_SUBWORD_EN to enable byte/half accesses (read-modify-write
// stores via the WRITE state); otherwise only aligned words are legal.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] writeData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] readData
);

    lsu_state_t  state;
    lsu_state_t  stateNext;

    logic        reqWe;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;

    logic        accept;
    logic        acceptBad;
    logic [31:0] loadData;
    logic [31:0] storeMerged;

    assign accept    = req_valid && (state == IDLE);
    assign acceptBad = isMisaligned(req_size, req_addr[1:0]);

    lsu_align u_align (
        .addrLo      (reqAddr[1:0]),
        .size        (reqSize),
        .isSigned    (reqSigned),
        .readData    (readData),
        .wdata       (reqWdata),
        .loadData    (loadData),
        .storeMerged (storeMerged)
    );

`ifdef LSU_SUBWORD_EN
    logic [31:0] mergedQ;
`else
    logic        unusedMerge;
    assign unusedMerge = ^storeMerged;
`endif

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and memory/handshake outputs, all derived from the state.
    always_comb begin
        stateNext  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        address    = '0;
        writeData  = '0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    stateNext = acceptBad ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                address   = {reqAddr[31:2], 2'b00};
                memRead   = 1'b1;
                stateNext = DONE;
                if (reqWe && (reqSize == SZ_WORD)) begin
                    memWrite  = 1'b1;
                    writeData = reqWdata;
                end
`ifdef LSU_SUBWORD_EN
                else if (reqWe) begin
                    stateNext = WRITE;
                end
`endif
            end
`ifdef LSU_SUBWORD_EN
            WRITE: begin
                address   = {reqAddr[31:2], 2'b00};
                memWrite  = 1'b1;
                writeData = mergedQ;
                stateNext = DONE;
            end
`endif
            DONE: begin
                resp_valid = 1'b1;
                stateNext  = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Request capture at accept, load result and merged store word in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqWe      <= 1'b0;
            reqSize    <= SZ_WORD;
            reqSigned  <= 1'b0;
            reqAddr    <= '0;
            reqWdata   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
`ifdef LSU_SUBWORD_EN
            mergedQ    <= '0;
`endif
        end else if (accept) begin
            reqWe      <= req_we;
            reqSize    <= req_size;
            reqSigned  <= req_signed;
            reqAddr    <= req_addr;
            reqWdata   <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= acceptBad;
        end else if (state == ACCESS) begin
            if (!reqWe) begin
                resp_rdata <= loadData;
            end
`ifdef LSU_SUBWORD_EN
            else begin
                mergedQ <= storeMerged;
            end
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural memory and
// reference model. Sub-word scenarios follow LSU_SUBWORD_EN.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem    [0:63];
    logic [31:0] refMem [0:63];
    logic [31:0] lastWrAddr;
    logic        fillEn;
    logic        plEn;
    int          plIdx;
    logic [31:0] plVal;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .address    (address),
        .writeData  (writeData),
        .memWrite   (memWrite),
        .memRead    (memRead),
        .readData   (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        return (32'(i) * 32'h01030507) ^ 32'hA5C3_0F17;
    endfunction

    // Data memory: combinational read, write on rising edge.
    assign readData = memRead ? mem[address[7:2]] : 32'hDEAD_0000;

    always @(posedge clk) begin
        if (fillEn) begin
            for (int i = 0; i < 64; i++) mem[i] <= pattern(i);
        end
        if (plEn) mem[plIdx] <= plVal;
        if (memWrite) begin
            mem[address[7:2]] <= writeData;
            lastWrAddr        <= address;
        end
    end

    // Reference: result of an access computed from size/alignment arithmetic.
    function automatic void ref_model(input bit we, input logic [1:0] size, input bit sgn,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output bit expErr, output logic [31:0] expRdata,
                                      output int expLat);
        int          nBytes;
        int          sh;
        logic [31:0] mask;
        logic [31:0] word;
        expErr   = (size == 2'b11);
`ifndef LSU_SUBWORD_EN
        if (size != 2'b10) expErr = 1'b1;
`endif
        nBytes   = 1 << int'(size);
        if (!expErr && (int'(addr[1:0]) % nBytes) != 0) expErr = 1'b1;
        expRdata = '0;
        expLat   = 1;
        if (expErr) return;
        sh   = int'(addr[1:0]) * 8;
        mask = (nBytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (nBytes * 8)) - 32'd1);
        word = refMem[addr[7:2]];
        if (!we) begin
            expRdata = (word >> sh) & mask;
            if (sgn && nBytes < 4 && expRdata[nBytes * 8 - 1]) expRdata = expRdata | ~mask;
            expLat = 2;
        end else begin
            refMem[addr[7:2]] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
            expLat = (nBytes == 4) ? 2 : 3;
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        plIdx = idx;
        plVal = val;
        plEn  = 1'b1;
        @(posedge clk);
        #1 plEn = 1'b0;
        refMem[idx] = val;
    endtask

    // Issue one request and observe its response (latency 0 = no response within the window).
    task automatic do_access(input bit we, input logic [1:0] size, input bit sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output int lat,
                             output logic readyAtReq, output logic respAfter,
                             output int memCycles, output int wrCycles);
        @(negedge clk);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        readyAtReq = req_ready;
        memCycles  = 0;
        wrCycles   = 0;
        lat        = 0;
        rdata      = '0;
        err        = 1'b0;
        respAfter  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = $urandom_range(0, 1);
        req_size   = 2'($urandom_range(0, 3));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (memRead || memWrite) memCycles++;
            if (memWrite) wrCycles++;
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            respAfter = resp_valid;
        end
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
        checks++; if (memRead !== 1'b0 || memWrite !== 1'b0) begin errors++; $display("FAIL reset_mem_ctrl got rd=%b wr=%b want 0/0", memRead, memWrite); end
        checks++; if (address !== 32'h0 || writeData !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got addr=%h wd=%h want 0/0", address, writeData); end
    endtask

    task automatic test_word_access();
        logic [31:0] rd; logic er; logic rdy; logic after; int lat; int mc; int wc;
        do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, rdy, after, mc, wc);
        refMem[4] = 32'hDEADBEEF;
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sw_ready got %b want 1", rdy); end
        checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency got %0d want 2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp got err=%b rdata=%h want 0/0", er, rd); end
        checks++; if (wc != 1) begin errors++; $display("FAIL sw_write_cycles got %0d want 1", wc); end
        checks++; if (lastWrAddr !== 32'h10) begin errors++; $display("FAIL sw_address got %h want 00000010", lastWrAddr); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got %h want deadbeef", mem[4]); end
        checks++; if (after !== 1'b0) begin errors++; $display("FAIL sw_pulse got %b want 0", after); end
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, rdy, after, mc, wc);
        checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data got %h err=%b want deadbeef err=0", rd, er); end
        checks++; if (wc != 0) begin errors++; $display("FAIL lw_no_write got %0d want 0", wc); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; logic rdy; logic after; int lat; int mc; int wc;
        do_access(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, er, lat, rdy, after, mc, wc);
        checks++; if (er !== 1'b1 || lat != 1) begin errors++; $display("FAIL lw_misaligned got err=%b lat=%0d want 1/1", er, lat); end
        checks++; if (mc != 0) begin errors++; $display("FAIL lw_misaligned_mem got %0d want 0", mc); end
        do_access(1'b1, 2'b11, 1'b0, 32'h20, 32'h1234, rd, er, lat, rdy, after, mc, wc);
        checks++; if (er !== 1'b1 || lat != 1 || mc != 0) begin errors++; $display("FAIL reserved_size got err=%b lat=%0d mem=%0d want 1/1/0", er, lat, mc); end
        checks++; if (mem[8] !== refMem[8]) begin errors++; $display("FAIL reserved_mem got %h want %h", mem[8], refMem[8]); end
    endtask

`ifdef LSU_SUBWORD_EN
    task automatic test_subword();
        logic [31:0] rd; logic er; logic rdy; logic after; int lat; int mc; int wc;
        preload(8, 32'h11223344);
        do_access(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er, lat, rdy, after, mc, wc);
        checks++; if (rd !== 32'h00000033 || er !== 1'b0 || lat != 2) begin errors++; $display("FAIL lb_21 got %h err=%b lat=%0d want 00000033/0/2", rd, er, lat); end
        do_access(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, rd, er, lat, rdy, after, mc, wc);
        refMem[8] = 32'h11AA3344;
        checks++; if (lat != 3 || wc != 1) begin errors++; $display("FAIL sb_22 got lat=%0d writes=%0d want 3/1", lat, wc); end
        checks++; if (mem[8] !== 32'h11AA3344) begin errors++; $display("FAIL sb_22_mem got %h want 11aa3344", mem[8]); end
        do_access(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, rd, er, lat, rdy, after, mc, wc);
        checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_22_signed got %h want ffffffaa", rd); end
        preload(8, 32'h11223344);
        do_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, rd, er, lat, rdy, after, mc, wc);
        refMem[8] = 32'hBEEF3344;
        checks++; if (lat != 3 || er !== 1'b0) begin errors++; $display("FAIL sh_22 got lat=%0d err=%b want 3/0", lat, er); end
        checks++; if (mem[8] !== 32'hBEEF3344) begin errors++; $display("FAIL sh_22_mem got %h want beef3344", mem[8]); end
        do_access(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, rd, er, lat, rdy, after, mc, wc);
        checks++; if (er !== 1'b1 || lat != 1 || mc != 0) begin errors++; $display("FAIL lh_misaligned got err=%b lat=%0d mem=%0d want 1/1/0", er, lat, mc); end
    endtask
`else
    task automatic test_subword_disabled();
        logic [31:0] rd; logic er; logic rdy; logic after; int lat; int mc; int wc;
        do_access(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er, lat, rdy, after, mc, wc);
        checks++; if (er !== 1'b1 || lat != 1) begin errors++; $display("FAIL lb_disabled got err=%b lat=%0d want 1/1", er, lat); end
        checks++; if (mc != 0) begin errors++; $display("FAIL lb_disabled_mem got %0d want 0", mc); end
        do_access(1'b1, 2'b01, 1'b0, 32'h22, 32'hBEEF, rd, er, lat, rdy, after, mc, wc);
        checks++; if (er !== 1'b1 || mc != 0) begin errors++; $display("FAIL sh_disabled got err=%b mem=%0d want 1/0", er, mc); end
        checks++; if (mem[8] !== refMem[8]) begin errors++; $display("FAIL sh_disabled_mem got %h want %h", mem[8], refMem[8]); end
    endtask
`endif

    task automatic test_reset_midflight();
        int found = 0;
        int expFound;
        int respSeen = 0;
        logic [1:0] sz;
        logic [31:0] ad;
`ifdef LSU_SUBWORD_EN
        sz = 2'b00; ad = 32'h31; expFound = 2;
`else
        sz = 2'b10; ad = 32'h30; expFound = 1;
`endif
        preload(12, 32'h55667788);
        @(negedge clk);
        req_we = 1'b1; req_size = sz; req_signed = 1'b0; req_addr = ad; req_wdata = 32'hAA; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (memWrite) begin found = c; break; end
        end
        checks++; if (found != expFound) begin errors++; $display("FAIL midflight_write_cycle got %0d want %0d", found, expFound); end
        rst_n = 1'b0;
        #1;
        checks++; if (memWrite !== 1'b0 || memRead !== 1'b0) begin errors++; $display("FAIL midflight_async got wr=%b rd=%b want 0/0", memWrite, memRead); end
        @(posedge clk);
        #1;
        checks++; if (mem[12] !== 32'h55667788) begin errors++; $display("FAIL midflight_mem got %h want 55667788", mem[12]); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midflight_ready got %b want 1", req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) respSeen++;
        end
        checks++; if (respSeen != 0) begin errors++; $display("FAIL midflight_no_resp got %0d want 0", respSeen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; logic rdy; logic after; int lat; int mc; int wc;
        bit we; logic [1:0] size; bit sgn; logic [31:0] addr; logic [31:0] wdata;
        bit expErr; logic [31:0] expRd; int expLat; int nb;
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            sgn   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            addr  = 32'($urandom_range(0, 255));
            nb    = 1 << int'(size);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(nb) - 32'd1);
            ref_model(we, size, sgn, addr, wdata, expErr, expRd, expLat);
            do_access(we, size, sgn, addr, wdata, rd, er, lat, rdy, after, mc, wc);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rand%0d_ready got %b want 1", i, rdy); end
            checks++; if (er !== expErr) begin errors++; $display("FAIL rand%0d_err got %b want %b (we=%0d sz=%0d a=%h)", i, er, expErr, we, size, addr); end
            checks++; if (lat != expLat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, expLat); end
            checks++; if (rd !== expRd) begin errors++; $display("FAIL rand%0d_rdata got %h want %h", i, rd, expRd); end
            checks++; if (mem[addr[7:2]] !== refMem[addr[7:2]]) begin errors++; $display("FAIL rand%0d_mem got %h want %h", i, mem[addr[7:2]], refMem[addr[7:2]]); end
            checks++; if (after !== 1'b0) begin errors++; $display("FAIL rand%0d_pulse got %b want 0", i, after); end
            if (expErr) begin
                checks++; if (mc != 0) begin errors++; $display("FAIL rand%0d_err_mem got %0d want 0", i, mc); end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        fillEn     = 1'b1;
        plEn       = 1'b0;
        plIdx      = 0;
        plVal      = '0;
        for (int i = 0; i < 64; i++) refMem[i] = pattern(i);
        #12;
        test_reset();
        @(negedge clk);
        fillEn = 1'b0;
        rst_n  = 1'b1;
        test_word_access();
        test_misaligned();
`ifdef LSU_SUBWORD_EN
        test_subword();
`else
        test_subword_disabled();
`endif
        test_reset_midflight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
